// File: rtl/i2c_color_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_color_poll_ctrl
// Description : Sequencer for the colour-sensor I2C read engine. Launches a
//               fixed burst register read periodically (i_enable) or on demand
//               (i_trigger), checks that the engine goes busy and finishes in
//               time, latches the returned 48-bit sample and flags failures.
// Optional    : define POLL_RETRY_EN to retry a failed read up to MAX_RETRY
//               times before raising o_err.
// Ports       : i_clk, i_rst (sync, active high)
//               i_enable / i_trigger / i_clr_err   - top-level control
//               o_rd_start, o_dev_addr, o_reg_addr, o_bytes_number,
//               i_rd_done, i_rd_data               - read engine handshake
//               o_sample, o_valid, o_busy, o_err, o_sample_cnt - status
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_color_poll_ctrl #(
   parameter logic [6:0]  DEV_ADDR       = 7'h29,
   parameter logic [7:0]  REG_ADDR       = 8'h96,
   parameter logic [2:0]  BYTES_M1       = 3'd5,
   parameter int unsigned POLL_CYCLES    = 1000000,
   parameter int unsigned BUSY_WAIT      = 8,
   parameter int unsigned TIMEOUT_CYCLES = 4096
`ifdef POLL_RETRY_EN
   ,parameter int unsigned MAX_RETRY     = 3
`endif
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_trigger,
   input  logic        i_clr_err,
   output logic        o_rd_start,
   output logic [6:0]  o_dev_addr,
   output logic [7:0]  o_reg_addr,
   output logic [2:0]  o_bytes_number,
   input  logic        i_rd_done,
   input  logic [47:0] i_rd_data,
   output logic [47:0] o_sample,
   output logic        o_valid,
   output logic        o_busy,
   output logic        o_err,
   output logic [15:0] o_sample_cnt
);

   localparam int unsigned CYC_MAX = (TIMEOUT_CYCLES > BUSY_WAIT) ? TIMEOUT_CYCLES : BUSY_WAIT;
   localparam int CYC_W  = (CYC_MAX > 2) ? $clog2(CYC_MAX) : 1;
   localparam int POLL_W = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;

   localparam logic [CYC_W-1:0]  BUSY_LAST    = CYC_W'(BUSY_WAIT - 1);
   localparam logic [CYC_W-1:0]  TIMEOUT_LAST = CYC_W'(TIMEOUT_CYCLES - 1);
   localparam logic [POLL_W-1:0] POLL_LAST    = POLL_W'(POLL_CYCLES - 1);

`ifdef POLL_RETRY_EN
   localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
`endif

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_LATCH     = 3'd4,
      S_FAIL      = 3'd5,
      S_WAIT_POLL = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
   logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
   logic [47:0]       sample_q, sample_d;
   logic [15:0]       sample_cnt_q, sample_cnt_d;
   logic              err_q, err_d;
`ifdef POLL_RETRY_EN
   logic [RETRY_W-1:0] retry_q, retry_d;
`endif

   assign o_dev_addr     = DEV_ADDR;
   assign o_reg_addr     = REG_ADDR;
   assign o_bytes_number = BYTES_M1;
   assign o_sample       = sample_q;
   assign o_sample_cnt   = sample_cnt_q;
   assign o_err          = err_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         cyc_cnt_q    <= '0;
         poll_cnt_q   <= '0;
         sample_q     <= '0;
         sample_cnt_q <= '0;
         err_q        <= 1'b0;
`ifdef POLL_RETRY_EN
         retry_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cyc_cnt_q    <= cyc_cnt_d;
         poll_cnt_q   <= poll_cnt_d;
         sample_q     <= sample_d;
         sample_cnt_q <= sample_cnt_d;
         err_q        <= err_d;
`ifdef POLL_RETRY_EN
         retry_q      <= retry_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      cyc_cnt_d    = cyc_cnt_q;
      poll_cnt_d   = poll_cnt_q;
      sample_d     = sample_q;
      sample_cnt_d = sample_cnt_q;
      err_d        = err_q;
`ifdef POLL_RETRY_EN
      retry_d      = retry_q;
`endif
      o_rd_start   = 1'b0;
      o_valid      = 1'b0;
      o_busy       = 1'b0;

      // A clear is overridden below if a failure sets the flag this cycle.
      if (i_clr_err) begin
         err_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if ((i_enable || i_trigger) && i_rd_done) begin
               state_d = S_START;
            end
         end

         S_START: begin
            o_rd_start = 1'b1;
            o_busy     = 1'b1;
            cyc_cnt_d  = '0;
            state_d    = S_WAIT_BUSY;
         end

         S_WAIT_BUSY: begin
            o_busy = 1'b1;
            if (!i_rd_done) begin
               cyc_cnt_d = '0;
               state_d   = S_WAIT_DONE;
            end else if (cyc_cnt_q == BUSY_LAST) begin
               state_d = S_FAIL;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
         end

         S_WAIT_DONE: begin
            o_busy = 1'b1;
            // Done is checked before the timeout so a simultaneous rise wins.
            // Sample and count are loaded on entry to S_LATCH so that they
            // are already updated while o_valid is high.
            if (i_rd_done) begin
               sample_d     = i_rd_data;
               sample_cnt_d = sample_cnt_q + 16'd1;
               state_d      = S_LATCH;
            end else if (cyc_cnt_q == TIMEOUT_LAST) begin
               state_d = S_FAIL;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
         end

         S_LATCH: begin
            o_busy     = 1'b1;
            o_valid    = 1'b1;
            poll_cnt_d = POLL_LAST;
            state_d    = S_WAIT_POLL;
`ifdef POLL_RETRY_EN
            retry_d    = '0;
`endif
         end

         S_FAIL: begin
`ifdef POLL_RETRY_EN
            if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + 1'b1;
               state_d = S_START;
            end else begin
               // Budget is per poll: the next poll starts with a fresh count.
               retry_d    = '0;
               err_d      = 1'b1;
               poll_cnt_d = POLL_LAST;
               state_d    = S_WAIT_POLL;
            end
`else
            err_d      = 1'b1;
            poll_cnt_d = POLL_LAST;
            state_d    = S_WAIT_POLL;
`endif
         end

         S_WAIT_POLL: begin
            if (i_trigger && i_rd_done) begin
               state_d = S_START;
            end else if (poll_cnt_q == '0) begin
               state_d = i_enable ? S_START : S_IDLE;
            end else begin
               poll_cnt_d = poll_cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
